// File: rtl/mux4_rr_arbiter.sv
// Four-way round-robin arbiter feeding a shared 4:1 data mux.
// A grant can be held for up to LOCK_MAX transferred beats while the winner keeps lock asserted.
module mux4_rr_arbiter #(
  parameter int WIDTH    = 8,
  parameter int LOCK_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           req,
  input  logic [3:0]           lock,
  input  logic [4*WIDTH-1:0]   data,
  input  logic                 out_ready,
  output logic [1:0]           sel,
  output logic [3:0]           gnt,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [3:0]           in_ready,
  output logic                 busy
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  localparam logic [3:0] LOCK_MAX_C = 4'(LOCK_MAX);

  logic [0:0] state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic [1:0] last_q, last_d;
  logic [3:0] gnt_q, gnt_d;
  logic [3:0] bcnt_q, bcnt_d;

  logic [1:0] winner;
  logic [1:0] cand;
  logic       beatXfer;
  logic       grantRelease;

  // Scan from last+4 down to last+1 so the closest requester after last is written last and wins.
  always_comb begin
    winner = last_q;
    cand   = last_q;
    for (int k = 4; k >= 1; k--) begin
      cand = last_q + k[1:0];
      if (req[cand]) begin
        winner = cand;
      end
    end
  end

  assign busy      = (state_q == GRANT);
  assign out_valid = busy & req[sel_q];
  assign out_data  = busy ? data[sel_q*WIDTH +: WIDTH] : '0;
  assign in_ready  = gnt_q & {4{out_ready}};
  assign sel       = sel_q;
  assign gnt       = gnt_q;

  assign beatXfer     = out_valid & out_ready;
  assign grantRelease = busy & ((beatXfer & (~lock[sel_q] | ((bcnt_q + 4'd1) == LOCK_MAX_C)))
                                | ~req[sel_q]);

  // last always equals sel while granted, so re-arbitration on release starts just past the current owner.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    bcnt_d  = bcnt_q;
    if ((state_q == IDLE) || grantRelease) begin
      if (|req) begin
        state_d = GRANT;
        sel_d   = winner;
        last_d  = winner;
        gnt_d   = 4'b0001 << winner;
        bcnt_d  = 4'd0;
      end else begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
        bcnt_d  = 4'd0;
      end
    end else if (beatXfer) begin
      bcnt_d = bcnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= 2'b00;
      last_q  <= 2'b11;
      gnt_q   <= 4'b0000;
      bcnt_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      bcnt_q  <= bcnt_d;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: directed scenarios with literal expectations plus
// randomized traffic, all compared every cycle against a behavioural round-robin model.
module tb_mux4_rr_arbiter;

  localparam int W  = 8;
  localparam int LM = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic [3:0]     req;
  logic [3:0]     lock;
  logic [4*W-1:0] data;
  logic           out_ready;
  logic [1:0]     sel;
  logic [3:0]     gnt;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [3:0]     in_ready;
  logic           busy;

  int total = 0;
  int bad   = 0;

  // Model state: owner index (-1 when idle), visible select, last winner, beats in this grant.
  int mGnt, mSel, mLast, mBeats;
  bit modelValid  = 1'b0;
  bit countGrants = 1'b0;
  int grantCnt[4];

  mux4_rr_arbiter #(.WIDTH(W), .LOCK_MAX(LM)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .data(data), .out_ready(out_ready),
    .sel(sel), .gnt(gnt), .out_valid(out_valid), .out_data(out_data),
    .in_ready(in_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pickNext(input int fromIdx, input logic [3:0] r);
    for (int k = 1; k <= 4; k++) begin
      if (r[(fromIdx + k) % 4]) return (fromIdx + k) % 4;
    end
    return -1;
  endfunction

  task automatic grantTo(input int w);
    mGnt   = w;
    mSel   = w;
    mLast  = w;
    mBeats = 0;
    if (countGrants) grantCnt[w]++;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic modelUpdate();
    int  w;
    bit  xfer;
    bit  done;
    if (reset) begin
      mGnt = -1; mSel = 0; mLast = 3; mBeats = 0;
      modelValid = 1'b1;
      return;
    end
    if (!modelValid) return;
    if (mGnt < 0) begin
      w = pickNext(mLast, req);
      if (w >= 0) grantTo(w);
    end else begin
      xfer = req[mGnt] && out_ready;
      done = !req[mGnt] || (xfer && (!lock[mGnt] || (mBeats + 1 == LM)));
      if (done) begin
        w = pickNext(mLast, req);
        if (w >= 0) grantTo(w);
        else begin
          mGnt = -1;
          mBeats = 0;
        end
      end else if (xfer) begin
        mBeats++;
      end
    end
  endtask

  task automatic checkOutput();
    logic [3:0]   expGnt;
    logic         expValid;
    logic [W-1:0] expData;
    logic [3:0]   expInReady;
    if (!modelValid) return;
    expGnt   = 4'b0000;
    expValid = 1'b0;
    expData  = '0;
    if (mGnt >= 0) begin
      expGnt   = 4'b0001 << mGnt;
      expValid = req[mGnt];
      expData  = data[mSel*W +: W];
    end
    expInReady = out_ready ? expGnt : 4'b0000;
    checkVal("model_sel", sel, mSel);
    checkVal("model_gnt", gnt, expGnt);
    checkVal("model_busy", busy, mGnt >= 0);
    checkVal("model_out_valid", out_valid, expValid);
    checkVal("model_out_data", out_data, expData);
    checkVal("model_in_ready", in_ready, expInReady);
    checkVal("gnt_onehot", $countones(gnt) <= 1, 1);
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l,
                               input logic rdy, input logic rs);
    req       = r;
    lock      = l;
    out_ready = rdy;
    reset     = rs;
    for (int i = 0; i < 4; i++) data[i*W +: W] = W'($urandom);
    #1;
    checkOutput();
    @(posedge clk);
    modelUpdate();
    @(negedge clk);
  endtask

  initial begin
    int sum;
    int cyc;
    int seq[4];
    req = 4'b0; lock = 4'b0; out_ready = 1'b0; reset = 1'b1; data = '0;

    // Reset state
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b1);
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b1);
    checkVal("rst_gnt", gnt, 4'b0000);
    checkVal("rst_busy", busy, 1'b0);
    checkVal("rst_sel", sel, 2'b00);
    checkVal("rst_in_ready", in_ready, 4'b0000);
    checkVal("rst_out_data", out_data, '0);

    // Alternating requesters 0 and 2, one beat each, no idle gaps
    seq = '{0, 2, 0, 2};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0101, 4'b0000, 1'b1, 1'b0);
      checkVal("alt_sel", sel, seq[i]);
      checkVal("alt_busy", busy, 1'b1);
    end

    // Release with nobody requesting: idle, sel holds
    applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);
    checkVal("idle_gnt", gnt, 4'b0000);
    checkVal("idle_sel", sel, 2'b10);
    checkVal("idle_busy", busy, 1'b0);

    // Locked burst of exactly LOCK_MAX beats, then requester 2 takes over
    applyStimulus(4'b0110, 4'b0010, 1'b1, 1'b0);
    checkVal("lock_first_gnt", gnt, 4'b0010);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b0110, 4'b0010, 1'b1, 1'b0);
      checkVal("lock_hold_gnt", gnt, 4'b0010);
    end
    applyStimulus(4'b0110, 4'b0010, 1'b1, 1'b0);
    checkVal("lock_release_gnt", gnt, 4'b0100);

    // Stalled grant to requester 3; stall cycles must not consume the lock budget
    applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b1000, 4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(4'b1000, 4'b1000, 1'b0, 1'b0);
      checkVal("stall_gnt", gnt, 4'b1000);
      checkVal("stall_valid", out_valid, 1'b1);
      checkVal("stall_in_ready", in_ready, 4'b0000);
    end
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b1100, 4'b1000, 1'b1, 1'b0);
      checkVal("stall_burst_gnt", gnt, 4'b1000);
    end
    applyStimulus(4'b1100, 4'b1000, 1'b1, 1'b0);
    checkVal("stall_release_gnt", gnt, 4'b0100);

    // Abort: requester 1 drops req while 2 is waiting
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0);
    checkVal("abort_pre_gnt", gnt, 4'b0010);
    applyStimulus(4'b0100, 4'b0000, 1'b0, 1'b0);
    checkVal("abort_gnt", gnt, 4'b0100);
    checkVal("abort_sel", sel, 2'b10);

    // Reset in the middle of a locked burst
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0);
    applyStimulus(4'b0001, 4'b0001, 1'b1, 1'b0);
    applyStimulus(4'b0001, 4'b0001, 1'b1, 1'b0);
    applyStimulus(4'b0001, 4'b0001, 1'b1, 1'b0);
    checkVal("burst_gnt", gnt, 4'b0001);
    applyStimulus(4'b0001, 4'b0001, 1'b1, 1'b1);
    checkVal("midrst_gnt", gnt, 4'b0000);
    checkVal("midrst_busy", busy, 1'b0);
    checkVal("midrst_valid", out_valid, 1'b0);
    checkVal("midrst_in_ready", in_ready, 4'b0000);
    checkVal("midrst_out_data", out_data, '0);
    applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0);
    checkVal("postrst_sel", sel, 2'b00);
    checkVal("postrst_gnt", gnt, 4'b0001);

    // Lone locked requester keeps being re-granted
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(4'b0010, 4'b0010, 1'b1, 1'b0);
      checkVal("lone_gnt", gnt, 4'b0010);
    end

    // Fairness: all four requesting, random out_ready, 400 grants
    for (int i = 0; i < 4; i++) grantCnt[i] = 0;
    countGrants = 1'b1;
    sum = 0;
    cyc = 0;
    while (sum < 400 && cyc < 4000) begin
      applyStimulus(4'b1111, 4'b0000, 1'($urandom_range(0, 1)), 1'b0);
      cyc++;
      sum = grantCnt[0] + grantCnt[1] + grantCnt[2] + grantCnt[3];
    end
    countGrants = 1'b0;
    checkVal("fair_bound", cyc < 4000, 1);
    for (int i = 0; i < 4; i++) begin
      checkVal("fair_cnt", (grantCnt[i] >= 95) && (grantCnt[i] <= 105), 1);
    end

    // Random traffic with occasional reset
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 49) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
